shape_color_classifier: RTL

- Second-generation frame-buffer analyser for the camera path.
- After capture, it scans the stored frame on request and reports:
  - dominant colour of object pixels;
  - coarse shape class (triangle/circle/square);
  - object pixel count;
  - first/last valid row.
- New relative to the first generation: parametrised geometry, pixel format, row stride, memory read latency and runtime thresholds, a start/busy/done handshake, and abort.

---
 rtl/scc_pkg.sv | 52 +++++
 rtl/shape_color_classifier_if.sv | 38 +++
 rtl/scc_tag_delay.sv | 40 ++++
 rtl/shape_color_classifier.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// Shared types and helpers for the shape/colour frame analyser.
// Channel helpers work on a zero-extended pixel so one function serves any channel width.
package scc_pkg;

    typedef enum logic [1:0] {
        ColNone  = 2'd0,
        ColRed   = 2'd1,
        ColGreen = 2'd2,
        ColBlue  = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        FigNone = 2'd0,
        FigTri  = 2'd1,
        FigCirc = 2'd2,
        FigSq   = 2'd3
    } figure_e;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StDrain,
        StClassify,
        StDone
    } state_e;

    localparam int unsigned MaxCw = 16;

    typedef logic [MaxCw-1:0]   chan_t;
    typedef logic [3*MaxCw-1:0] wide_pix_t;

    // sel: 2 = red (MSBs), 1 = green, 0 = blue
    function automatic chan_t chan_of(input wide_pix_t pix, input int unsigned cw,
                                      input int unsigned sel);
        wide_pix_t sh;
        sh = pix >> (sel * cw);
        return sh[MaxCw-1:0] & chan_t'((32'd1 << cw) - 32'd1);
    endfunction

    function automatic chan_t red_of(input wide_pix_t pix, input int unsigned cw);
        return chan_of(pix, cw, 2);
    endfunction

    function automatic chan_t green_of(input wide_pix_t pix, input int unsigned cw);
        return chan_of(pix, cw, 1);
    endfunction

    function automatic chan_t blue_of(input wide_pix_t pix, input int unsigned cw);
        return chan_of(pix, cw, 0);
    endfunction

endpackage

// File: rtl/shape_color_classifier_if.sv
// Host control, frame-buffer read port and result signals of the classifier.
// slave = classifier side, master = host/memory side.
interface shape_color_classifier_if #(
    parameter int unsigned N  = 120,
    parameter int unsigned M  = 160,
    parameter int unsigned CW = 4
);
    localparam int unsigned AW = $clog2(N * M);
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

    logic            start;
    logic            abort;
    logic [3*CW-1:0] thr;
    logic [AW-1:0]   rd_addr;
    logic            rd_en;
    logic [3*CW-1:0] rd_data;
    logic            busy;
    logic            done;
    logic            results_valid;
    logic [1:0]      color;
    logic [1:0]      figure;
    logic [AW:0]     obj_count;
    logic [RW-1:0]   row_first;
    logic [RW-1:0]   row_last;

    modport slave (
        input  start, abort, thr, rd_data,
        output rd_addr, rd_en, busy, done, results_valid, color, figure, obj_count,
               row_first, row_last
    );

    modport master (
        output start, abort, thr, rd_data,
        input  rd_addr, rd_en, busy, done, results_valid, color, figure, obj_count,
               row_first, row_last
    );

endinterface

// File: rtl/scc_tag_delay.sv
// Carries {valid, last_col, row} alongside each frame-buffer read so the tag emerges
// in the same cycle as the returned pixel.
module scc_tag_delay #(
    parameter int unsigned Depth = 1,
    parameter int unsigned RowW  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            tag_valid,
    input  logic            tag_last_col,
    input  logic [RowW-1:0] tag_row,
    output logic            dly_valid,
    output logic            dly_last_col,
    output logic [RowW-1:0] dly_row
);
    typedef struct packed {
        logic            valid;
        logic            last_col;
        logic [RowW-1:0] row;
    } tag_t;

    tag_t pipe_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) pipe_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(Depth); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{valid: tag_valid, last_col: tag_last_col, row: tag_row};
            for (int i = 1; i < int'(Depth); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dly_valid    = pipe_q[Depth-1].valid;
    assign dly_last_col = pipe_q[Depth-1].last_col;
    assign dly_row      = pipe_q[Depth-1].row;

endmodule

// File: rtl/shape_color_classifier.sv
// Frame-buffer scanner: streams sampled rows out of memory, accumulates object statistics
// and classifies the object's dominant colour and coarse shape.
module shape_color_classifier
    import scc_pkg::*;
#(
    parameter int unsigned N         = 120,
    parameter int unsigned M         = 160,
    parameter int unsigned CW        = 4,
    parameter int unsigned ROW_STEP  = 3,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MIN_WIDTH = 7
) (
    input logic                     clk,
    input logic                     rst,
    shape_color_classifier_if.slave bus
);
    localparam int unsigned AW     = $clog2(N * M);
    localparam int unsigned RW     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ColW   = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned WW     = $clog2(M + 1);
    localparam int unsigned VW     = $clog2(N + 1);
    localparam int unsigned SW     = CW + AW;
    localparam int unsigned DW     = $clog2(RD_LAT + 1);
    localparam int unsigned RowAdv = (ROW_STEP - 1) * M + 1;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q;
    logic [ColW-1:0] col_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   drain_q;
    logic            scanning, last_col, last_row, scan_go;

    assign scanning = (state_q == StScan);
    assign last_col = (col_q == ColW'(M - 1));
    assign last_row = (32'(row_q) + ROW_STEP >= N);
    // Abort outranks start, so a coincident start never opens a scan.
    assign scan_go  = (state_q == StIdle || state_q == StDone) && bus.start && !bus.abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (bus.start) state_d = StScan;
            StScan:     if (last_col && last_row) state_d = StDrain;
            StDrain:    if (drain_q == DW'(RD_LAT - 1)) state_d = StClassify;
            StClassify: state_d = StDone;
            StDone:     state_d = bus.start ? StScan : StIdle;
            default:    state_d = StIdle;
        endcase
        if (bus.abort) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            drain_q <= (state_q == StDrain) ? drain_q + DW'(1) : '0;
            if (scan_go) begin
                row_q  <= '0;
                col_q  <= '0;
                addr_q <= '0;
            end else if (scanning) begin
                if (last_col) begin
                    col_q  <= '0;
                    row_q  <= row_q + RW'(ROW_STEP);
                    addr_q <= addr_q + AW'(RowAdv);
                end else begin
                    col_q  <= col_q + ColW'(1);
                    addr_q <= addr_q + AW'(1);
                end
            end
        end
    end

    logic          tag_valid, tag_last;
    logic [RW-1:0] tag_row;

    scc_tag_delay #(
        .Depth (RD_LAT),
        .RowW  (RW)
    ) u_tag_delay (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.abort),
        .tag_valid    (scanning),
        .tag_last_col (last_col),
        .tag_row      (row_q),
        .dly_valid    (tag_valid),
        .dly_last_col (tag_last),
        .dly_row      (tag_row)
    );

    logic [CW-1:0] pix_r, pix_g, pix_b, thr_r, thr_g, thr_b;
    logic          obj, row_ok;
    logic [WW-1:0] width_q, prev_q, width_new;
    logic [AW:0]   cnt_q;
    logic [SW-1:0] sum_r_q, sum_g_q, sum_b_q;
    logic [VW-1:0] v_q, w_q;
    logic          have_first_q;
    logic [RW-1:0] first_q, last_q;

    assign pix_r     = CW'(red_of(wide_pix_t'(bus.rd_data), CW));
    assign pix_g     = CW'(green_of(wide_pix_t'(bus.rd_data), CW));
    assign pix_b     = CW'(blue_of(wide_pix_t'(bus.rd_data), CW));
    assign thr_r     = CW'(red_of(wide_pix_t'(bus.thr), CW));
    assign thr_g     = CW'(green_of(wide_pix_t'(bus.thr), CW));
    assign thr_b     = CW'(blue_of(wide_pix_t'(bus.thr), CW));
    assign obj       = (pix_r >= thr_r) || (pix_g >= thr_g) || (pix_b >= thr_b);
    assign width_new = width_q + WW'(obj);
    assign row_ok    = width_new > WW'(MIN_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q      <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            sum_r_q      <= '0;
            sum_g_q      <= '0;
            sum_b_q      <= '0;
            v_q          <= '0;
            w_q          <= '0;
            have_first_q <= 1'b0;
            first_q      <= '0;
            last_q       <= '0;
        end else if (scan_go) begin
            width_q      <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            sum_r_q      <= '0;
            sum_g_q      <= '0;
            sum_b_q      <= '0;
            v_q          <= '0;
            w_q          <= '0;
            have_first_q <= 1'b0;
            first_q      <= '0;
            last_q       <= '0;
        end else if (tag_valid) begin
            if (obj) begin
                cnt_q   <= cnt_q + (AW + 1)'(1);
                sum_r_q <= sum_r_q + SW'(pix_r);
                sum_g_q <= sum_g_q + SW'(pix_g);
                sum_b_q <= sum_b_q + SW'(pix_b);
            end
            if (tag_last) begin
                // Row width history tracks every sampled row, valid or not.
                width_q <= '0;
                prev_q  <= width_new;
                if (row_ok) begin
                    v_q <= v_q + VW'(1);
                    if (prev_q < width_new) w_q <= w_q + VW'(1);
                    if (!have_first_q) begin
                        first_q      <= tag_row;
                        have_first_q <= 1'b1;
                    end
                    last_q <= tag_row;
                end
            end else begin
                width_q <= width_new;
            end
        end
    end

    color_e  color_c;
    figure_e figure_c;

    always_comb begin
        color_c = ColNone;
        if (sum_r_q > sum_g_q && sum_r_q > sum_b_q)      color_c = ColRed;
        else if (sum_g_q > sum_r_q && sum_g_q > sum_b_q) color_c = ColGreen;
        else if (sum_b_q > sum_r_q && sum_b_q > sum_g_q) color_c = ColBlue;
    end

    always_comb begin
        figure_c = FigNone;
        if (v_q >= w_q && w_q > (v_q >> 1))             figure_c = FigTri;
        else if ((v_q >> 1) >= w_q && w_q > (v_q >> 2)) figure_c = FigCirc;
        else if (v_q != '0)                             figure_c = FigSq;
    end

    color_e        color_q;
    figure_e       figure_q;
    logic [AW:0]   res_cnt_q;
    logic [RW-1:0] res_first_q, res_last_q;
    logic          valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q     <= ColNone;
            figure_q    <= FigNone;
            res_cnt_q   <= '0;
            res_first_q <= '0;
            res_last_q  <= '0;
            valid_q     <= 1'b0;
        end else if (bus.abort || scan_go) begin
            valid_q <= 1'b0;
        end else if (state_q == StClassify) begin
            color_q     <= color_c;
            figure_q    <= figure_c;
            res_cnt_q   <= cnt_q;
            res_first_q <= first_q;
            res_last_q  <= last_q;
            valid_q     <= 1'b1;
        end
    end

    assign bus.rd_en         = scanning;
    assign bus.rd_addr       = scanning ? addr_q : '0;
    assign bus.busy          = scanning || (state_q == StDrain) || (state_q == StClassify);
    assign bus.done          = (state_q == StDone);
    assign bus.results_valid = valid_q;
    assign bus.color         = color_q;
    assign bus.figure        = figure_q;
    assign bus.obj_count     = res_cnt_q;
    assign bus.row_first     = res_first_q;
    assign bus.row_last      = res_last_q;

endmodule
